// File: rtl/cmd_frame_parser.sv
// cmd_frame_parser
//   Assembles framed commands from the USB receive byte stream and holds the
//   waveform-control registers that feed sig_gen.
//   Frame: 0xA5, OPC, DHI, DLO [, CKS]. A frame is judged in the cycle after
//   the rx_valid of its last byte. In that cycle either the target register
//   updates and cmd_ok pulses, or err_frame / err_range pulses and nothing
//   changes.
//   Optional feature macro: FRAME_CHECKSUM_EN. When it is defined a fifth
//   byte CKS = OPC ^ DHI ^ DLO is required.
//
// Handshake: rx_valid_i is a single-cycle strobe with no back-pressure. A
//   byte is consumed on every cycle in which rx_valid_i is high. Back-to-back
//   strobes are allowed.
//
// Ports
//   clk            100 MHz system clock
//   rst_n          synchronous active-low reset
//   rx_byte_i      received byte, valid while rx_valid_i is high
//   rx_valid_i     one-cycle byte strobe
//   state_o        waveform select
//   state_freq_o   frequency word
//   state_amp_o    amplitude code
//   state_phase_o  phase offset
//   cmd_ok_o       pulse: frame applied
//   err_frame_o    pulse: bad opcode or bad checksum
//   err_range_o    pulse: payload out of range
//   err_timeout_o  pulse: inter-byte gap expired inside a frame
//   frame_cnt_o    applied-frame count, wraps 255 -> 0
//   fsm_state_o    current parser FSM state (debug)
module cmd_frame_parser #(
  parameter logic [4:0]  DEF_STATE      = 5'd4,
  parameter logic [11:0] DEF_FREQ       = 12'd1,
  parameter logic [2:0]  DEF_AMP        = 3'd7,
  parameter logic [7:0]  DEF_PHASE      = 8'd0,
  parameter logic [4:0]  MAX_STATE      = 5'd7,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter int          TO_W           = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_valid_i,
  output logic [4:0]  state_o,
  output logic [11:0] state_freq_o,
  output logic [2:0]  state_amp_o,
  output logic [7:0]  state_phase_o,
  output logic        cmd_ok_o,
  output logic        err_frame_o,
  output logic        err_range_o,
  output logic        err_timeout_o,
  output logic [7:0]  frame_cnt_o,
  output logic [2:0]  fsm_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OPC  = 3'd1,
    S_DHI  = 3'd2,
    S_DLO  = 3'd3
`ifdef FRAME_CHECKSUM_EN
    , S_CKS = 3'd4
`endif
  } fsm_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  fsm_e            fsm_q, fsm_d;
  logic [7:0]      opc_q, opc_d;
  logic [7:0]      dhi_q, dhi_d;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]      dlo_q, dlo_d;
`endif
  logic [TO_W-1:0] to_q, to_d;
  logic [4:0]      state_q, state_d;
  logic [11:0]     freq_q, freq_d;
  logic [2:0]      amp_q, amp_d;
  logic [7:0]      phase_q, phase_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            ok_q, ok_d;
  logic            efr_q, efr_d;
  logic            erg_q, erg_d;
  logic            eto_q, eto_d;

  logic            fin;      // last byte of a frame is present this cycle
  logic [7:0]      fin_dlo;  // DLO of the frame being judged
  logic            cks_ok;
  logic            expire;
  logic [15:0]     d16;

  always_comb begin
    fsm_d   = fsm_q;
    opc_d   = opc_q;
    dhi_d   = dhi_q;
`ifdef FRAME_CHECKSUM_EN
    dlo_d   = dlo_q;
`endif
    state_d = state_q;
    freq_d  = freq_q;
    amp_d   = amp_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    ok_d    = 1'b0;
    efr_d   = 1'b0;
    erg_d   = 1'b0;
    eto_d   = 1'b0;
    fin     = 1'b0;
    fin_dlo = rx_byte_i;
    cks_ok  = 1'b1;
    // A byte arriving in the expiry cycle wins over the timeout.
    expire  = (fsm_q != S_IDLE) && !rx_valid_i && (to_q == TO_LAST);
    to_d    = (rx_valid_i || fsm_q == S_IDLE || expire) ? '0 : to_q + TO_W'(1);

    case (fsm_q)
      S_IDLE: if (rx_valid_i && rx_byte_i == 8'hA5) fsm_d = S_OPC;
      S_OPC: if (rx_valid_i) begin
        opc_d = rx_byte_i;
        fsm_d = S_DHI;
      end
      S_DHI: if (rx_valid_i) begin
        dhi_d = rx_byte_i;
        fsm_d = S_DLO;
      end
`ifdef FRAME_CHECKSUM_EN
      S_DLO: if (rx_valid_i) begin
        dlo_d = rx_byte_i;
        fsm_d = S_CKS;
      end
      S_CKS: if (rx_valid_i) begin
        fin     = 1'b1;
        fin_dlo = dlo_q;
        cks_ok  = (rx_byte_i == (opc_q ^ dhi_q ^ dlo_q));
        fsm_d   = S_IDLE;
      end
`else
      S_DLO: if (rx_valid_i) begin
        fin   = 1'b1;
        fsm_d = S_IDLE;
      end
`endif
      default: fsm_d = S_IDLE;
    endcase

    if (expire) begin
      fsm_d = S_IDLE;
      eto_d = 1'b1;
    end

    d16 = {dhi_q, fin_dlo};
    if (fin) begin
      // Checksum failure outranks opcode checks, which outrank range checks.
      if (!cks_ok) begin
        efr_d = 1'b1;
      end else begin
        case (opc_q)
          8'h01: if (dhi_q == 8'd0 && fin_dlo <= {3'b000, MAX_STATE}) begin
            state_d = fin_dlo[4:0];
            ok_d    = 1'b1;
          end else erg_d = 1'b1;
          8'h02: if (d16[15:12] == 4'd0 && d16 != 16'd0) begin
            freq_d = d16[11:0];
            ok_d   = 1'b1;
          end else erg_d = 1'b1;
          8'h03: if (dhi_q == 8'd0 && fin_dlo <= 8'd7) begin
            amp_d = fin_dlo[2:0];
            ok_d  = 1'b1;
          end else erg_d = 1'b1;
          8'h04: if (dhi_q == 8'd0) begin
            phase_d = fin_dlo;
            ok_d    = 1'b1;
          end else erg_d = 1'b1;
          default: efr_d = 1'b1;
        endcase
      end
      if (ok_d) cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= S_IDLE;
      opc_q   <= 8'd0;
      dhi_q   <= 8'd0;
`ifdef FRAME_CHECKSUM_EN
      dlo_q   <= 8'd0;
`endif
      to_q    <= '0;
      state_q <= DEF_STATE;
      freq_q  <= DEF_FREQ;
      amp_q   <= DEF_AMP;
      phase_q <= DEF_PHASE;
      cnt_q   <= 8'd0;
      ok_q    <= 1'b0;
      efr_q   <= 1'b0;
      erg_q   <= 1'b0;
      eto_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      opc_q   <= opc_d;
      dhi_q   <= dhi_d;
`ifdef FRAME_CHECKSUM_EN
      dlo_q   <= dlo_d;
`endif
      to_q    <= to_d;
      state_q <= state_d;
      freq_q  <= freq_d;
      amp_q   <= amp_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
      efr_q   <= efr_d;
      erg_q   <= erg_d;
      eto_q   <= eto_d;
    end
  end

  assign state_o       = state_q;
  assign state_freq_o  = freq_q;
  assign state_amp_o   = amp_q;
  assign state_phase_o = phase_q;
  assign cmd_ok_o      = ok_q;
  assign err_frame_o   = efr_q;
  assign err_range_o   = erg_q;
  assign err_timeout_o = eto_q;
  assign frame_cnt_o   = cnt_q;
  assign fsm_state_o   = fsm_q;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Testbench for cmd_frame_parser. The timeout is shortened to keep run time
// small. The reference model works on whole frames held in a byte queue.
module tb_cmd_frame_parser;

  localparam int TO = 200;
`ifdef FRAME_CHECKSUM_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [7:0]  rx_byte_i = 8'd0;
  logic        rx_valid_i = 1'b0;
  logic [4:0]  state_o;
  logic [11:0] state_freq_o;
  logic [2:0]  state_amp_o;
  logic [7:0]  state_phase_o;
  logic        cmd_ok_o, err_frame_o, err_range_o, err_timeout_o;
  logic [7:0]  frame_cnt_o;
  logic [2:0]  fsm_state_o;

  cmd_frame_parser #(
    .TIMEOUT_CYCLES(TO),
    .TO_W          (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_byte_i    (rx_byte_i),
    .rx_valid_i   (rx_valid_i),
    .state_o      (state_o),
    .state_freq_o (state_freq_o),
    .state_amp_o  (state_amp_o),
    .state_phase_o(state_phase_o),
    .cmd_ok_o     (cmd_ok_o),
    .err_frame_o  (err_frame_o),
    .err_range_o  (err_range_o),
    .err_timeout_o(err_timeout_o),
    .frame_cnt_o  (frame_cnt_o),
    .fsm_state_o  (fsm_state_o)
  );

  // reference model
  logic [7:0]  m_frame[$];
  int          m_gap;
  int          m_state, m_freq, m_amp, m_phase, m_cnt;
  logic [3:0]  exp_q[$];   // expected {ok, frame, range, timeout} per cycle

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input int obs, input int expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_frame.delete();
    m_gap   = 0;
    m_state = 4;
    m_freq  = 1;
    m_amp   = 7;
    m_phase = 0;
    m_cnt   = 0;
  endtask

  // Judge a complete frame; returns {ok, frame_err, range_err, 0}.
  function automatic logic [3:0] judge();
    int opc, dv, dlo;
    opc = m_frame[1];
    dv  = m_frame[2] * 256 + m_frame[3];
    dlo = m_frame[3];
`ifdef FRAME_CHECKSUM_EN
    if (m_frame[4] != (m_frame[1] ^ m_frame[2] ^ m_frame[3])) return 4'b0100;
`endif
    case (opc)
      1: if (dv <= 7) begin m_state = dlo; end else return 4'b0010;
      2: if (dv >= 1 && dv <= 4095) begin m_freq = dv; end else return 4'b0010;
      3: if (dv <= 7) begin m_amp = dlo; end else return 4'b0010;
      4: if (dv <= 255) begin m_phase = dlo; end else return 4'b0010;
      default: return 4'b0100;
    endcase
    m_cnt = (m_cnt + 1) % 256;
    return 4'b1000;
  endfunction

  // driver: one clock cycle of stimulus, then check every output
  task automatic step(input bit rst, input bit v, input logic [7:0] b);
    logic [3:0] e;
    logic [3:0] got;
    rst_n      = !rst;
    rx_valid_i = v;
    rx_byte_i  = b;
    e = 4'b0000;
    if (rst) begin
      model_reset();
    end else if (v) begin
      m_gap = 0;
      if (m_frame.size() == 0) begin
        if (b == 8'hA5) m_frame.push_back(b);
      end else begin
        m_frame.push_back(b);
        if (m_frame.size() == FLEN) begin
          e = judge();
          m_frame.delete();
        end
      end
    end else if (m_frame.size() != 0) begin
      m_gap++;
      if (m_gap == TO) begin
        e = 4'b0001;
        m_frame.delete();
        m_gap = 0;
      end
    end
    exp_q.push_back(e);
    @(negedge clk);
    e   = exp_q.pop_front();
    got = {cmd_ok_o, err_frame_o, err_range_o, err_timeout_o};
    chk("pulses", int'(got), int'(e));
    chk("state", int'(state_o), m_state);
    chk("state_freq", int'(state_freq_o), m_freq);
    chk("state_amp", int'(state_amp_o), m_amp);
    chk("state_phase", int'(state_phase_o), m_phase);
    chk("frame_cnt", int'(frame_cnt_o), m_cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00);
  endtask

  task automatic send_frame(input logic [7:0] opc, input logic [7:0] dhi,
                            input logic [7:0] dlo, input bit bad_cks);
    logic [7:0] c;
    c = opc ^ dhi ^ dlo;
    if (bad_cks) c = ~c;
    step(0, 1, 8'hA5);
    step(0, 1, opc);
    step(0, 1, dhi);
    step(0, 1, dlo);
`ifdef FRAME_CHECKSUM_EN
    step(0, 1, c);
`endif
  endtask

  initial begin
    logic [7:0] b;
    model_reset();
    @(negedge clk);
    // reset held, then released with no input
    step(1, 0, 8'h00);
    step(1, 1, 8'hA5);
    idle(3);

    // frequency write, then range error, then bad opcode
    send_frame(8'h02, 8'h03, 8'hE8, 0);
    idle(2);
    send_frame(8'h01, 8'h00, 8'h09, 0);
    send_frame(8'h09, 8'h00, 8'h00, 0);
    idle(1);

    // timeout after header+opcode, then a good phase write
    step(0, 1, 8'hA5);
    step(0, 1, 8'h04);
    idle(TO + 3);
    send_frame(8'h04, 8'h00, 8'h80, 0);

    // junk bytes dropped, back-to-back frame
    step(0, 1, 8'h11);
    step(0, 1, 8'h22);
    send_frame(8'h03, 8'h00, 8'h05, 0);
    // new header in the cycle right after the apply
    send_frame(8'h01, 8'h00, 8'h07, 0);
    send_frame(8'h02, 8'h10, 8'h00, 0);   // D[15:12] != 0
    send_frame(8'h02, 8'h00, 8'h00, 0);   // D == 0
    send_frame(8'h02, 8'h0F, 8'hFF, 0);   // upper bound
    send_frame(8'h03, 8'h00, 8'h08, 0);
    send_frame(8'h04, 8'h01, 8'h00, 0);
    send_frame(8'h01, 8'h01, 8'h03, 0);   // DHI != 0
    send_frame(8'h00, 8'h00, 8'h00, 0);
    send_frame(8'h05, 8'hA5, 8'hA5, 0);   // A5 inside a frame is data

    // byte arriving exactly in the expiry cycle is accepted
    step(0, 1, 8'hA5);
    step(0, 1, 8'h04);
    idle(TO - 1);
    step(0, 1, 8'h00);
    idle(TO - 1);
    step(0, 1, 8'h33);

    // reset in the middle of a frame discards it
    step(0, 1, 8'hA5);
    step(0, 1, 8'h03);
    step(1, 0, 8'h00);
    step(0, 1, 8'h00);
    step(0, 1, 8'h02);
    idle(2);

    // bad checksum (only meaningful with the checksum build)
    send_frame(8'h03, 8'h00, 8'h02, 1);
    idle(1);

    // 256 good frames wrap the counter
    for (int i = 0; i < 256; i++)
      send_frame(8'h04, 8'h00, 8'(i), 0);
    idle(2);

    // randomized byte stream
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 200) == 0) begin
        step(1, 0, 8'h00);
      end else if ($urandom_range(0, 60) == 0) begin
        idle($urandom_range(TO - 2, TO + 1));
      end else if ($urandom_range(0, 4) == 0) begin
        send_frame(8'($urandom_range(0, 5)), 8'($urandom_range(0, 1) * $urandom_range(0, 20)),
                   8'($urandom_range(0, 255)), $urandom_range(0, 5) == 0);
      end else if ($urandom_range(0, 3) == 0) begin
        step(0, 0, 8'h00);
      end else begin
        case ($urandom_range(0, 9))
          0, 1, 2: b = 8'hA5;
          3, 4:    b = 8'($urandom_range(0, 5));
          5, 6, 7: b = 8'($urandom_range(0, 12));
          default: b = 8'($urandom_range(0, 255));
        endcase
        step(0, 1, b);
      end
    end
    idle(TO + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
